// File: rtl/rx_speed_change_sequencer.sv
// RX speed-change sequencer: holds the RX datapath, waits for per-lane PhyStatus, then switches GEN.
// Optional WAIT_PHY timeout is enabled with macro RX_SPDCHG_TIMEOUT_EN.
module rx_speed_change_sequencer #(
  parameter int unsigned DRAIN_CYCLES   = 4,
  parameter int unsigned TIMEOUT_CYCLES = 1024,
  parameter logic [2:0]  RESET_GEN      = 3'd1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_gen,
  output logic        req_ready,
  input  logic [4:0]  numberOfDetectedLanes,
  input  logic [15:0] PhyStatus,
  output logic [2:0]  GEN,
  output logic        datapathHold,
  output logic        disableDescrambler,
  output logic        done,
  output logic        error
);

  typedef enum logic [2:0] {IDLE, DRAIN, WAIT_PHY, UPDATE, RESUME} state_t;

  localparam int unsigned DW = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [2:0]    r_gen;
  logic [2:0]    r_target;
  logic [4:0]    r_lanes;
  logic [DW-1:0] r_drain;
  logic [15:0]   r_mask;
  logic          r_done;
  logic          r_err;

  logic          w_accept;
  logic          w_legal;
  logic          w_change;
  logic          w_drain_last;
  logic [4:0]    w_lanes_clamped;
  logic [15:0]   w_active;
  logic [15:0]   w_mask_nxt;
  logic          w_all;

`ifdef RX_SPDCHG_TIMEOUT_EN
  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] r_tmo;
  logic [2:0]    r_old_gen;
  logic          w_tmo;
  assign w_tmo = (r_tmo == TW'(TIMEOUT_CYCLES - 1));
`endif

  assign w_accept     = req_valid && (r_state == IDLE);
  assign w_legal      = (req_gen >= 3'd1) && (req_gen <= 3'd5);
  assign w_change     = w_accept && w_legal && (req_gen != r_gen);
  assign w_drain_last = (r_drain == DW'(DRAIN_CYCLES - 1));

  always_comb begin
    w_lanes_clamped = numberOfDetectedLanes;
    if (numberOfDetectedLanes == 5'd0)       w_lanes_clamped = 5'd1;
    else if (numberOfDetectedLanes > 5'd16)  w_lanes_clamped = 5'd16;
  end

  always_comb begin
    w_active = '0;
    for (int unsigned i = 0; i < 16; i++) w_active[i] = (5'(i) < r_lanes);
  end

  // Completion includes lanes reporting in the current cycle.
  assign w_mask_nxt = r_mask | (PhyStatus & w_active);
  assign w_all      = (w_mask_nxt == w_active);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:     if (w_change) w_state_nxt = DRAIN;
      DRAIN:    if (w_drain_last) w_state_nxt = WAIT_PHY;
      WAIT_PHY: begin
        if (w_all) w_state_nxt = UPDATE;
`ifdef RX_SPDCHG_TIMEOUT_EN
        else if (w_tmo) w_state_nxt = IDLE;
`endif
      end
      UPDATE:   w_state_nxt = RESUME;
      RESUME:   w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready          = (r_state == IDLE);
    datapathHold       = (r_state != IDLE);
    disableDescrambler = (r_state != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_gen    <= RESET_GEN;
      r_target <= '0;
      r_lanes  <= '0;
      r_drain  <= '0;
      r_mask   <= '0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
`ifdef RX_SPDCHG_TIMEOUT_EN
      r_tmo     <= '0;
      r_old_gen <= RESET_GEN;
`endif
    end else begin
      r_done <= 1'b0;
      r_err  <= 1'b0;
      case (r_state)
        IDLE: if (w_accept) begin
          r_target <= req_gen;
          r_lanes  <= w_lanes_clamped;
          r_drain  <= '0;
`ifdef RX_SPDCHG_TIMEOUT_EN
          r_old_gen <= r_gen;
`endif
          if (!w_legal)              r_err  <= 1'b1;
          else if (req_gen == r_gen) r_done <= 1'b1;
        end
        DRAIN: begin
          r_drain <= r_drain + 1'b1;
          if (w_drain_last) begin
            r_mask <= '0;
`ifdef RX_SPDCHG_TIMEOUT_EN
            r_tmo <= '0;
`endif
          end
        end
        WAIT_PHY: begin
          r_mask <= w_mask_nxt;
`ifdef RX_SPDCHG_TIMEOUT_EN
          r_tmo <= r_tmo + 1'b1;
          if (!w_all && w_tmo) begin
            r_err <= 1'b1;
            r_gen <= r_old_gen;
          end
`endif
        end
        UPDATE:  r_gen  <= r_target;
        RESUME:  r_done <= 1'b1;
        default: ;
      endcase
    end
  end

  assign GEN   = r_gen;
  assign done  = r_done;
  assign error = r_err;

endmodule

// File: tb/tb_rx_speed_change_sequencer.sv
// Directed bench: expected done/error pulses (kind, GEN, cycle) are queued at request time and checked when they appear.
module tb_rx_speed_change_sequencer;

  localparam int DRAIN = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic [2:0]  req_gen;
  logic        req_ready;
  logic [4:0]  lanes;
  logic [15:0] phy;
  logic [2:0]  gen;
  logic        hold;
  logic        ddesc;
  logic        done;
  logic        error;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  typedef struct {
    bit         is_err;
    logic [2:0] gen;
    int         cyc;
  } exp_t;
  exp_t sb[$];

  rx_speed_change_sequencer #(
    .DRAIN_CYCLES  (DRAIN),
    .TIMEOUT_CYCLES(1024),
    .RESET_GEN     (3'd1)
  ) dut (
    .clk                  (clk),
    .reset                (rst_n),
    .req_valid            (req_valid),
    .req_gen              (req_gen),
    .req_ready            (req_ready),
    .numberOfDetectedLanes(lanes),
    .PhyStatus            (phy),
    .GEN                  (gen),
    .datapathHold         (hold),
    .disableDescrambler   (ddesc),
    .done                 (done),
    .error                (error)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (rst_n === 1'b1 && (done === 1'b1 || error === 1'b1)) begin
      if (sb.size() == 0) begin
        chk("unexpected_pulse", {30'd0, done, error}, 32'd0);
      end else begin
        e = sb.pop_front();
        chk("pulse_kind", {30'd0, done, error}, e.is_err ? 32'd1 : 32'd2);
        chk("pulse_gen", {29'd0, gen}, {29'd0, e.gen});
        chk("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  // Called at a negedge; lat < 0 means no pulse is expected.
  task automatic request(input logic [2:0] g, input logic [4:0] n, input bit is_err,
                         input logic [2:0] exp_gen, input int lat);
    exp_t e;
    chk("req_ready_idle", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1;
    req_gen   = g;
    lanes     = n;
    if (lat >= 0) begin
      e.is_err = is_err;
      e.gen    = exp_gen;
      e.cyc    = cyc + lat;
      sb.push_back(e);
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic drain_wait();
    for (int i = 0; i < DRAIN; i++) begin
      chk("hold_drain", {31'd0, hold}, 32'd1);
      chk("ddesc_drain", {31'd0, ddesc}, 32'd1);
      @(negedge clk);
    end
  endtask

  task automatic settle(input string tag);
    repeat (3) @(negedge clk);
    chk(tag, sb.size(), 32'd0);
    chk("hold_idle", {31'd0, hold}, 32'd0);
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "timeout");
  end

  initial begin
    logic [15:0] pulses [5];
    rst_n = 1'b0; req_valid = 1'b0; req_gen = '0; lanes = 5'd4; phy = '0;
    repeat (3) @(negedge clk);
    chk("rst_gen", {29'd0, gen}, 32'd1);
    chk("rst_ready", {31'd0, req_ready}, 32'd1);
    chk("rst_hold", {31'd0, hold}, 32'd0);
    chk("rst_ddesc", {31'd0, ddesc}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_error", {31'd0, error}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Same rate: done one cycle after acceptance, no hold.
    request(3'd1, 5'd4, 1'b0, 3'd1, 1);
    chk("same_no_hold", {31'd0, hold}, 32'd0);
    @(negedge clk);
    chk("same_no_hold2", {31'd0, hold}, 32'd0);
    settle("sb_same1");

    request(3'd7, 5'd4, 1'b1, 3'd1, 1);
    chk("illegal_no_hold", {31'd0, hold}, 32'd0);
    settle("sb_illegal7");
    chk("gen_after_illegal", {29'd0, gen}, 32'd1);

    // 1 -> 3 on 4 lanes, staggered PhyStatus (W=5), second request during DRAIN ignored.
    pulses[0] = 16'hF0F1; pulses[1] = 16'h0003; pulses[2] = 16'h0000;
    pulses[3] = 16'h0004; pulses[4] = 16'h0008;
    request(3'd3, 5'd4, 1'b0, 3'd3, DRAIN + 5 + 3);
    req_valid = 1'b1; req_gen = 3'd5;
    chk("ready_busy", {31'd0, req_ready}, 32'd0);
    @(negedge clk);
    chk("ready_busy2", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    drain_wait_rest: for (int i = 1; i < DRAIN; i++) begin
      chk("hold_drain", {31'd0, hold}, 32'd1);
      @(negedge clk);
    end
    for (int i = 0; i < 5; i++) begin
      chk("hold_wait", {31'd0, hold}, 32'd1);
      chk("gen_wait", {29'd0, gen}, 32'd1);
      phy = pulses[i];
      @(negedge clk);
    end
    phy = '0;
    chk("hold_update", {31'd0, hold}, 32'd1);
    chk("gen_update", {29'd0, gen}, 32'd1);
    @(negedge clk);
    chk("hold_resume", {31'd0, hold}, 32'd1);
    chk("gen_resume", {29'd0, gen}, 32'd3);
    @(negedge clk);
    chk("hold_after_done", {31'd0, hold}, 32'd0);
    chk("ddesc_after_done", {31'd0, ddesc}, 32'd0);
    settle("sb_main");

    request(3'd3, 5'd4, 1'b0, 3'd3, 1);
    settle("sb_same3");
    request(3'd0, 5'd4, 1'b1, 3'd3, 1);
    settle("sb_illegal0");
    request(3'd6, 5'd4, 1'b1, 3'd3, 1);
    settle("sb_illegal6");

    // Lane count 0 behaves as 1: needs PhyStatus[0], arriving in WAIT cycle 2.
    request(3'd5, 5'd0, 1'b0, 3'd5, DRAIN + 2 + 3);
    drain_wait();
    phy = 16'h0000; @(negedge clk);
    phy = 16'h0001; @(negedge clk);
    phy = '0;
    settle("sb_lanes0");

    // Lane count 20 behaves as 16: lane 15 arrives last.
    request(3'd2, 5'd20, 1'b0, 3'd2, DRAIN + 2 + 3);
    drain_wait();
    phy = 16'h7FFF; @(negedge clk);
    phy = 16'h8000; @(negedge clk);
    phy = '0;
    settle("sb_lanes20");

    // 2 lanes, PhyStatus only on inactive lanes: never completes; then reset mid-WAIT_PHY.
    request(3'd4, 5'd2, 1'b0, 3'd4, -1);
    drain_wait();
    phy = 16'hFFFC;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      chk("stall_hold", {31'd0, hold}, 32'd1);
      chk("stall_done", {30'd0, done, error}, 32'd0);
    end
    chk("stall_gen", {29'd0, gen}, 32'd2);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_gen", {29'd0, gen}, 32'd1);
    chk("abort_ready", {31'd0, req_ready}, 32'd1);
    chk("abort_hold", {31'd0, hold}, 32'd0);
    chk("abort_ddesc", {31'd0, ddesc}, 32'd0);
    chk("abort_pulses", {30'd0, done, error}, 32'd0);
    phy = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    request(3'd1, 5'd4, 1'b0, 3'd1, 1);
    settle("sb_after_reset");

    chk("sb_final", sb.size(), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rx_speed_change_sequencer.md
RX_SPEED_CHANGE_SEQUENCER -- requirements
Module: rx_speed_change_sequencer

Interface
REQ-001 The block SHALL have parameter DRAIN_CYCLES, default 4: cycles the datapath is held before PHY handshake.
REQ-002 The block SHALL have parameter TIMEOUT_CYCLES, default 1024: maximum cycles to wait for PhyStatus.
REQ-003 The block SHALL have parameter RESET_GEN, default 3'd1: rate after reset.
REQ-004 The block SHALL have port: clk  input  1  sole clock, all flops rising edge.
REQ-005 The block SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-006 The block SHALL have port: req_valid  input  1  speed-change request.
REQ-007 The block SHALL have port: req_gen  input  3  target rate, legal 1..5.
REQ-008 The block SHALL have port: req_ready  output  1  high only in IDLE.
REQ-009 The block SHALL have port: numberOfDetectedLanes  input  5  active lane count, sampled at acceptance.
REQ-010 The block SHALL have port: PhyStatus  input  16  per-lane PHY completion pulse.
REQ-011 The block SHALL have port: GEN  output  3  current rate driven to the RX datapath.
REQ-012 The block SHALL have port: datapathHold  output  1  forces RxValid low into the PIPE stage.
REQ-013 The block SHALL have port: disableDescrambler  output  1  descrambler bypass during the change.
REQ-014 The block SHALL have port: done  output  1  one-cycle pulse, change complete.
REQ-015 The block SHALL have port: error  output  1  one-cycle pulse, request rejected or timed out.

Function
REQ-016 The FSM SHALL have states IDLE, DRAIN, WAIT_PHY, UPDATE and RESUME, one-hot or binary as chosen.
REQ-017 Acceptance SHALL occur when req_valid and req_ready are both high; req_gen, the lane count and the old GEN are registered on that edge.
REQ-018 A legal req_gen that differs from GEN SHALL transition IDLE->DRAIN and assert datapathHold and disableDescrambler on the next cycle.
REQ-019 If req_gen equals GEN, the block SHALL stay in IDLE and pulse done one cycle after acceptance, with no hold.
REQ-020 If req_gen is 0, 6 or 7, the block SHALL stay in IDLE and pulse error one cycle after acceptance, with GEN unchanged.
REQ-021 In DRAIN the block SHALL count DRAIN_CYCLES cycles, then go to WAIT_PHY and clear the lane-seen mask.
REQ-022 In WAIT_PHY, each PhyStatus[i] for i < lane count SHALL set sticky bit i; PhyStatus on inactive lanes SHALL be ignored.
REQ-023 When all active bits are set, including bits set in the same cycle, the block SHALL go to UPDATE.
REQ-024 In UPDATE, GEN SHALL load the target value (one cycle), then the FSM SHALL go to RESUME.
REQ-025 RESUME SHALL last one cycle: datapathHold and disableDescrambler deassert on exit, done pulses, and the FSM returns to IDLE.
REQ-026 A lane count of 0 SHALL be treated as 1, and a value above 16 as 16.
REQ-027 Requests arriving outside IDLE SHALL be neither accepted nor queued.
REQ-028 Total latency for a successful change SHALL be acceptance -> done = DRAIN_CYCLES + (PhyStatus wait) + 3 cycles.

Reset
REQ-029 Asserting reset (low) SHALL force: state=IDLE, GEN=RESET_GEN, req_ready=1, datapathHold=0, disableDescrambler=0, done=0, error=0, counters=0, mask=0.
REQ-030 Reset asserted mid-sequence SHALL abort the sequence immediately, with GEN returning to RESET_GEN and not to the target.

Configuration
REQ-031 With macro RX_SPDCHG_TIMEOUT_EN defined, a WAIT_PHY cycle counter SHALL reach TIMEOUT_CYCLES without completion and then: keep the old GEN, deassert the holds, pulse error, and return to IDLE.
REQ-032 Without RX_SPDCHG_TIMEOUT_EN, WAIT_PHY SHALL wait indefinitely, the timeout counter SHALL be absent, and error SHALL pulse only for illegal req_gen.

Verification
REQ-033 Scenario: after reset, GEN=1 and req_gen=3 with 4 lanes; PhyStatus[3:0] pulses on different cycles -> GEN=3, done pulses exactly once, and datapathHold is high for the full sequence.
REQ-034 Scenario: req_gen=1 while GEN=1 -> done one cycle later, and datapathHold never rises.
REQ-035 Scenario: req_gen=7 -> error pulse, and GEN stays at 1.
REQ-036 Scenario: 2 lanes, with PhyStatus only on lanes 2..15 -> no completion; with TIMEOUT_EN and TIMEOUT_CYCLES=1024 -> error at cycle 1024 of WAIT_PHY and GEN unchanged.
REQ-037 Scenario: reset pulsed low during WAIT_PHY -> all outputs are at reset values in the same cycle, and GEN=RESET_GEN.
REQ-038 Scenario: a second req_valid during DRAIN -> ignored, req_ready=0, and only one done pulse occurs.
